// File: rtl/md_pkg.sv
// Shared op encodings, FSM states and decode helpers for the multiply/divide unit.
// MD_MADD_EN adds the multiply-accumulate ops; otherwise their codes decode as NOP.
package md_pkg;

  localparam logic [3:0] MD_NOP   = 4'h0;
  localparam logic [3:0] MD_MULT  = 4'h1;
  localparam logic [3:0] MD_MULTU = 4'h2;
  localparam logic [3:0] MD_DIV   = 4'h3;
  localparam logic [3:0] MD_DIVU  = 4'h4;
  localparam logic [3:0] MD_MTHI  = 4'h5;
  localparam logic [3:0] MD_MTLO  = 4'h6;
  localparam logic [3:0] MD_MADD  = 4'h7;
  localparam logic [3:0] MD_MADDU = 4'h8;
  localparam logic [3:0] MD_MSUB  = 4'h9;
  localparam logic [3:0] MD_MSUBU = 4'hA;

  typedef enum logic {MD_IDLE = 1'b0, MD_RUN = 1'b1} md_state_e;

  // How the pending value is folded into {hi,lo} at commit.
  typedef enum logic [1:0] {PendSet, PendKeep, PendAdd, PendSub} pend_kind_e;

  function automatic logic is_mul(input logic [3:0] op);
    logic r;
    r = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MD_MADD_EN
    r = r || (op == MD_MADD) || (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface md_unit_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic [3:0]       md_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cancel;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, md_op, a, b, cancel, input busy, hi, lo);
  modport slave  (input start, md_op, a, b, cancel, output busy, hi, lo);
endinterface

// File: rtl/md_core.sv
// Combinational signed/unsigned product and quotient/remainder on operand magnitudes.
module md_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic [2*WIDTH-1:0] prod,
  output logic [WIDTH-1:0]   quot,
  output logic [WIDTH-1:0]   rem,
  output logic               div_zero
);
  logic               neg_a, neg_b;
  logic [WIDTH-1:0]   mag_a, mag_b, mag_q, mag_r;
  logic [2*WIDTH-1:0] mag_p;

  // Most-negative operand has magnitude 2^(WIDTH-1), which fits unsigned, so
  // MIN / -1 falls out naturally as quotient MIN, remainder 0.
  always_comb begin
    neg_a    = is_signed & a[WIDTH-1];
    neg_b    = is_signed & b[WIDTH-1];
    mag_a    = neg_a ? -a : a;
    mag_b    = neg_b ? -b : b;
    mag_p    = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
    prod     = (neg_a ^ neg_b) ? -mag_p : mag_p;
    div_zero = (b == '0);
    mag_q    = div_zero ? '0 : mag_a / mag_b;
    mag_r    = div_zero ? '0 : mag_a % mag_b;
    quot     = (neg_a ^ neg_b) ? -mag_q : mag_q;
    rem      = neg_a ? -mag_r : mag_r;
  end
endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; busy drives the hazard-unit stall.
// MD_MADD_EN enables MADD/MADDU/MSUB/MSUBU accumulating into {hi,lo} at commit.
module md_unit
  import md_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  md_unit_if.slave  bus
);
  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;
  localparam logic [CntW-1:0] MulCnt = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivCnt = CntW'(DIV_CYCLES);

  md_state_e          state_q;
  logic [CntW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] pend_q;
  pend_kind_e         kind_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic [2*WIDTH-1:0] prod, pend_val, hilo, commit_val;
  logic [WIDTH-1:0]   quot, rem;
  logic               div_zero, accept;
  pend_kind_e         pend_kind;

  md_core #(.WIDTH(WIDTH)) u_core (
    .a        (bus.a),
    .b        (bus.b),
    .is_signed(is_signed_op(bus.md_op)),
    .prod     (prod),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero)
  );

  assign accept = bus.start & ~bus.cancel & (state_q == MD_IDLE);
  assign hilo   = {hi_q, lo_q};

  always_comb begin
    pend_val  = prod;
    pend_kind = PendSet;
    if (is_div(bus.md_op)) begin
      pend_val  = {rem, quot};
      pend_kind = div_zero ? PendKeep : PendSet;
    end
`ifdef MD_MADD_EN
    if (bus.md_op == MD_MADD || bus.md_op == MD_MADDU) pend_kind = PendAdd;
    if (bus.md_op == MD_MSUB || bus.md_op == MD_MSUBU) pend_kind = PendSub;
`endif
  end

  // Accumulating ops read {hi,lo} as it stands at commit, not at accept.
  always_comb begin
    commit_val = hilo;
    unique case (kind_q)
      PendSet:  commit_val = pend_q;
      PendKeep: commit_val = hilo;
`ifdef MD_MADD_EN
      PendAdd:  commit_val = hilo + pend_q;
      PendSub:  commit_val = hilo - pend_q;
`endif
      default:  commit_val = hilo;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      pend_q  <= '0;
      kind_q  <= PendSet;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      unique case (state_q)
        MD_IDLE: begin
          if (accept) begin
            if (is_mul(bus.md_op) || is_div(bus.md_op)) begin
              state_q <= MD_RUN;
              cnt_q   <= is_div(bus.md_op) ? DivCnt : MulCnt;
              pend_q  <= pend_val;
              kind_q  <= pend_kind;
            end else if (bus.md_op == MD_MTHI) begin
              hi_q <= bus.a;
            end else if (bus.md_op == MD_MTLO) begin
              lo_q <= bus.a;
            end
          end
        end
        MD_RUN: begin
          if (bus.cancel) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CntW'(1)) begin
            {hi_q, lo_q} <= commit_val;
            state_q      <= MD_IDLE;
            cnt_q        <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign bus.busy = (state_q == MD_RUN);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
